// File: rtl/stage_monitor.sv
// Stage monitor: checks stage/epoch sequencing and per-stage cycle counts
// against a programmable limit table, and queues one event per stage.
module stage_monitor #(
  parameter int Na    = 8,
  parameter int Nc    = 4,
  parameter int Nd    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [Na-1:0] count_step,
  input  logic [Nc-1:0] count_stage,
  input  logic [Nd-1:0] count_epoch,
  input  logic          last_step,
  input  logic [Nc-1:0] limit_stage,
  input  logic [Nd-1:0] stop_epoch,
  input  logic          cfg_we,
  input  logic [Nc-1:0] cfg_addr,
  input  logic [Na-1:0] cfg_data,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic [Nc-1:0] evt_stage,
  output logic [Nd-1:0] evt_epoch,
  output logic [Na:0]   evt_steps,
  output logic          err_seq,
  output logic          err_len,
  output logic          run_done,
  output logic [7:0]    drop_cnt
);

  localparam int NT = 1 << Nc;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = Nc + Nd + Na + 1;

  logic [Na-1:0] tbl [NT];
  logic [EW-1:0] mem [DEPTH];

  logic          armed;
  logic [Nc-1:0] prev_stage;
  logic [Nd-1:0] prev_epoch;
  logic          prev_last;
  logic [Na:0]   cyc;
  logic [Na:0]   exp_len;

  logic          boundary;
  logic          seq_ok;
  logic          seq_bad;
  logic          len_bad;
  logic          done_hit;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;
  logic [EW-1:0] head;

  // Step count is carried on the interface but not needed for checking.
  logic unused_step;
  assign unused_step = ^count_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NT; i++) tbl[i] <= '1;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  assign exp_len  = {1'b0, tbl[prev_stage]} + (Na+1)'(1);
  assign boundary = armed && (count_stage != prev_stage);

  always_comb begin
    seq_ok = 1'b0;
    if (prev_stage < limit_stage)
      seq_ok = (count_stage == prev_stage + Nc'(1))
            && (count_epoch == prev_epoch);
    else if (prev_stage == limit_stage)
      seq_ok = (count_stage == '0)
            && (count_epoch == prev_epoch + Nd'(1));
  end

  assign seq_bad = boundary ? (!seq_ok || !prev_last)
                 : (armed && (count_epoch != prev_epoch));
  assign len_bad  = boundary && (cyc != exp_len);
  assign done_hit = boundary && (prev_stage == limit_stage)
                 && (prev_epoch == stop_epoch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      prev_stage <= '0;
      prev_epoch <= '0;
      prev_last  <= 1'b0;
      cyc        <= '0;
      err_seq    <= 1'b0;
      err_len    <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      armed      <= 1'b1;
      prev_stage <= count_stage;
      prev_epoch <= count_epoch;
      prev_last  <= last_step;
      if (!armed || boundary)
        cyc <= (Na+1)'(1);
      else if (!(&cyc))
        cyc <= cyc + (Na+1)'(1);
      err_seq  <= err_seq  | seq_bad;
      err_len  <= err_len  | len_bad;
      run_done <= run_done | done_hit;
    end
  end

  // Event FIFO, first-word fall-through; a pop frees room for a push.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && evt_ready;
  assign do_push = boundary && (!full || pop);
  assign drop    = boundary && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= {prev_stage, prev_epoch, cyc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = !empty;
  assign {evt_stage, evt_epoch, evt_steps} = evt_valid ? head : '0;

endmodule

// File: tb/tb_stage_monitor.sv
// Bench for stage_monitor: vector tables plus an event scoreboard.
module tb_stage_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count_step;
  logic [3:0]  count_stage;
  logic [15:0] count_epoch;
  logic        last_step;
  logic [3:0]  limit_stage;
  logic [15:0] stop_epoch;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        evt_ready;
  logic        evt_valid;
  logic [3:0]  evt_stage;
  logic [15:0] evt_epoch;
  logic [8:0]  evt_steps;
  logic        err_seq;
  logic        err_len;
  logic        run_done;
  logic [7:0]  drop_cnt;

  stage_monitor dut (
    .clk(clk), .rst(rst),
    .count_step(count_step),
    .count_stage(count_stage),
    .count_epoch(count_epoch),
    .last_step(last_step),
    .limit_stage(limit_stage),
    .stop_epoch(stop_epoch),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_stage(evt_stage),
    .evt_epoch(evt_epoch),
    .evt_steps(evt_steps),
    .err_seq(err_seq), .err_len(err_len),
    .run_done(run_done),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s; int e; bit l; bit r;
    bit we; int a; int d;
    bit p; int es; int ee; int en;
  } vec_t;

  typedef struct { int s; int e; int n; } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic vec_t row(int s, int e, bit l, bit r);
    vec_t v;
    v = '{s, e, l, r, 1'b0, 0, 0, 1'b0, 0, 0, 0};
    return v;
  endfunction

  function automatic vec_t cw(int s, int e, bit l, bit r,
                              int a, int d);
    vec_t v;
    v = row(s, e, l, r);
    v.we = 1'b1; v.a = a; v.d = d;
    return v;
  endfunction

  function automatic vec_t ev(int s, int e, bit l, bit r,
                              int es, int ee, int en);
    vec_t v;
    v = row(s, e, l, r);
    v.p = 1'b1; v.es = es; v.ee = ee; v.en = en;
    return v;
  endfunction

  task automatic apply(vec_t v);
    count_stage = 4'(v.s);
    count_epoch = 16'(v.e);
    last_step   = v.l;
    evt_ready   = v.r;
    cfg_we      = v.we;
    cfg_addr    = 4'(v.a);
    cfg_data    = 8'(v.d);
    if (v.p) q.push_back('{v.es, v.ee, v.en});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int lim, int stop);
    rst = 1'b0;
    q.delete();
    apply(row(0, 0, 0, 1));
    apply(row(0, 0, 0, 1));
    limit_stage = 4'(lim);
    stop_epoch  = 16'(stop);
    rst = 1'b1;
  endtask

  // Scoreboard: pop on handshake, otherwise head must hold.
  always @(negedge clk) begin
    if (rst && evt_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_evt", 32'(evt_valid), 32'd0);
      end else if (evt_ready) begin
        mon_e = q.pop_front();
        chk("evt_stage", 32'(evt_stage), 32'(mon_e.s));
        chk("evt_epoch", 32'(evt_epoch), 32'(mon_e.e));
        chk("evt_steps", 32'(evt_steps), 32'(mon_e.n));
      end else begin
        chk("hold_stage", 32'(evt_stage), 32'(q[0].s));
        chk("hold_epoch", 32'(evt_epoch), 32'(q[0].e));
        chk("hold_steps", 32'(evt_steps), 32'(q[0].n));
      end
    end
  end

  vec_t vn[$];
  vec_t vb[$];

  initial begin
    vn.push_back(cw(0, 0, 0, 1, 0, 2));
    vn.push_back(cw(0, 0, 0, 1, 1, 3));
    vn.push_back(row(0, 0, 1, 1));
    vn.push_back(ev(1, 0, 0, 1, 0, 0, 3));
    vn.push_back(row(1, 0, 0, 1));
    vn.push_back(row(1, 0, 0, 1));
    vn.push_back(row(1, 0, 1, 1));
    vn.push_back(ev(0, 1, 0, 1, 1, 0, 4));
    vn.push_back(row(0, 1, 0, 1));
    vn.push_back(row(0, 1, 1, 1));
    vn.push_back(ev(1, 1, 0, 1, 0, 1, 3));
    vn.push_back(row(1, 1, 0, 1));
    vn.push_back(row(1, 1, 0, 1));
    vn.push_back(row(1, 1, 1, 1));
    vn.push_back(ev(0, 2, 0, 1, 1, 1, 4));
    vn.push_back(row(0, 2, 0, 1));

    vb.push_back(row(0, 0, 1, 0));
    vb.push_back(ev(1, 0, 1, 0, 0, 0, 1));
    vb.push_back(ev(0, 1, 1, 0, 1, 0, 1));
    vb.push_back(ev(1, 1, 1, 0, 0, 1, 1));
    vb.push_back(ev(0, 2, 1, 0, 1, 1, 1));
    vb.push_back(row(1, 2, 1, 0));
    vb.push_back(row(0, 3, 1, 0));
    vb.push_back(row(0, 3, 1, 0));

    rst = 1'b0;
    count_step = '0;
    count_stage = '0;
    count_epoch = '0;
    last_step = 1'b0;
    limit_stage = 4'd1;
    stop_epoch = 16'd1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    evt_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_stage", 32'(evt_stage), 32'd0);
    chk("rst_epoch", 32'(evt_epoch), 32'd0);
    chk("rst_steps", 32'(evt_steps), 32'd0);
    chk("rst_err_seq", 32'(err_seq), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_done", 32'(run_done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // normal run
    do_reset(1, 1);
    for (int i = 0; i < vn.size(); i++) begin
      apply(vn[i]);
      if (i == 12)
        chk("done_early", 32'(run_done), 32'd0);
    end
    chk("norm_done", 32'(run_done), 32'd1);
    chk("norm_seq", 32'(err_seq), 32'd0);
    chk("norm_len", 32'(err_len), 32'd0);
    chk("norm_drain", 32'(q.size()), 32'd0);

    // wrong length: stage 0 held five cycles
    do_reset(1, 1);
    apply(cw(0, 0, 0, 1, 0, 2));
    apply(cw(0, 0, 0, 1, 1, 3));
    apply(row(0, 0, 0, 1));
    apply(row(0, 0, 0, 1));
    apply(row(0, 0, 1, 1));
    apply(ev(1, 0, 0, 1, 0, 0, 5));
    apply(row(1, 0, 0, 1));
    chk("len_err_len", 32'(err_len), 32'd1);
    chk("len_err_seq", 32'(err_seq), 32'd0);
    chk("len_drain", 32'(q.size()), 32'd0);

    // skipped stage 0 -> 2
    do_reset(3, 1);
    apply(row(0, 0, 0, 1));
    apply(row(0, 0, 0, 1));
    apply(row(0, 0, 1, 1));
    chk("skip_pre", 32'(err_seq), 32'd0);
    apply(ev(2, 0, 0, 1, 0, 0, 3));
    apply(row(2, 0, 0, 1));
    chk("skip_seq", 32'(err_seq), 32'd1);
    chk("skip_drain", 32'(q.size()), 32'd0);

    // backpressure, then push+pop while full
    do_reset(1, 100);
    for (int i = 0; i < vb.size(); i++)
      apply(vb[i]);
    chk("bp_valid", 32'(evt_valid), 32'd1);
    chk("bp_drop", 32'(drop_cnt), 32'd2);
    chk("bp_queued", 32'(q.size()), 32'd4);
    apply(ev(1, 3, 1, 1, 0, 3, 2));
    chk("pp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 6; i++)
      apply(row(1, 3, 1, 1));
    chk("pp_valid", 32'(evt_valid), 32'd0);
    chk("pp_drain", 32'(q.size()), 32'd0);
    chk("pp_drop2", 32'(drop_cnt), 32'd2);
    chk("pp_seq", 32'(err_seq), 32'd0);

    // asynchronous reset with three events queued
    do_reset(1, 100);
    apply(row(0, 0, 1, 0));
    apply(ev(1, 0, 1, 0, 0, 0, 1));
    apply(ev(0, 1, 1, 0, 1, 0, 1));
    apply(ev(1, 1, 1, 0, 0, 1, 1));
    chk("ar_pre_valid", 32'(evt_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_valid", 32'(evt_valid), 32'd0);
    chk("ar_steps", 32'(evt_steps), 32'd0);
    chk("ar_len", 32'(err_len), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(row(3, 7, 0, 1));
    apply(row(3, 7, 0, 1));
    chk("rearm_seq", 32'(err_seq), 32'd0);
    chk("rearm_len", 32'(err_len), 32'd0);
    chk("rearm_valid", 32'(evt_valid), 32'd0);
    chk("rearm_drop", 32'(drop_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
